// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: 2-flop sync, stable-window filter, rise/fall/long-press ticks.
// Level and edge ticks change WinMax+1 clocks after a new input level is first sampled.
module debouncer_multi #(
  parameter int NumCh      = 4,
  parameter int ClkRate    = 10_000_000,
  parameter int Baud       = 10_000,
  parameter int LongCycles = 5_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] sw_i,
  output logic [NumCh-1:0] db_level_o,
  output logic [NumCh-1:0] rise_tick_o,
  output logic [NumCh-1:0] fall_tick_o,
  output logic [NumCh-1:0] long_tick_o,
  output logic             event_o
);

  localparam int WinMax = ClkRate / Baud;
  localparam int CntW   = (WinMax > 1) ? $clog2(WinMax) : 1;
  localparam int HcW    = (LongCycles > 0) ? $clog2(LongCycles + 1) : 1;

  localparam logic [CntW-1:0] CntTop = CntW'(WinMax - 1);
  localparam logic [HcW-1:0]  HcTop  = HcW'(LongCycles);
  localparam logic [HcW-1:0]  HcPre  = HcW'(LongCycles - 1);

  logic [NumCh-1:0] rise_n;
  logic [NumCh-1:0] fall_n;
  logic [NumCh-1:0] long_n;

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    logic            s1_q;
    logic            s2_q;
    logic [CntW-1:0] cnt_q;
    logic [HcW-1:0]  hc_q;
    logic            db_q;
    logic            rise_q;
    logic            fall_q;
    logic            long_q;
    logic            stable;
    logic            upd;

    assign stable    = (cnt_q == CntTop);
    assign upd       = stable && (s2_q != db_q);
    assign rise_n[i] = upd && s2_q;
    assign fall_n[i] = upd && !s2_q;
    // hc reaches LongCycles on this edge exactly when it currently sits one below
    assign long_n[i] = db_q && (hc_q == HcPre);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        cnt_q  <= '0;
        hc_q   <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
      end else begin
        s1_q <= sw_i[i];
        s2_q <= s1_q;

        if (s1_q != s2_q) begin
          cnt_q <= '0;
        end else if (cnt_q < CntTop) begin
          cnt_q <= cnt_q + 1'b1;
        end

        if (upd) begin
          db_q <= s2_q;
        end
        rise_q <= rise_n[i];
        fall_q <= fall_n[i];
        long_q <= long_n[i];

        if (!db_q) begin
          hc_q <= '0;
        end else if (hc_q < HcTop) begin
          hc_q <= hc_q + 1'b1;
        end
      end
    end

    assign db_level_o[i]  = db_q;
    assign rise_tick_o[i] = rise_q;
    assign fall_tick_o[i] = fall_q;
    assign long_tick_o[i] = long_q;
  end

  // Registered from the same next-state terms as the ticks, so it aligns with them exactly
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_o <= 1'b0;
    end else begin
      event_o <= |(rise_n | fall_n | long_n);
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: WinMax=10, LongCycles=30, four channels.
module tb_debouncer_multi;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] sw_i  = 4'b0000;
  logic [3:0] db_level_o;
  logic [3:0] rise_tick_o;
  logic [3:0] fall_tick_o;
  logic [3:0] long_tick_o;
  logic       event_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise0_cyc = 0;

  debouncer_multi #(
    .NumCh(4), .ClkRate(100), .Baud(10), .LongCycles(30)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sw_i(sw_i),
    .db_level_o(db_level_o), .rise_tick_o(rise_tick_o), .fall_tick_o(fall_tick_o),
    .long_tick_o(long_tick_o), .event_o(event_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    sw_i  = 4'b0000;
    #3;
    checks++;
    if ({db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o} !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected 0", {db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o});
    end
    step();
    step();
    rst_i = 1'b0;
    step();
    checks++;
    if ({db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o} !== 17'd0) begin
      errors++;
      $display("FAIL reset_first_clk: outputs=%h expected 0", {db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o});
    end
    repeat (15) step();
  endtask

  task automatic test_rise();
    int c0 = cyc;
    int rel = -1;
    int n = 0;
    logic evt = 1'b0;
    logic db_before = 1'b1;
    sw_i[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 10) db_before = db_level_o[0];
      if (rise_tick_o[0]) begin
        n++;
        if (rel < 0) begin
          rel = cyc - c0 - 1;
          evt = event_o;
          rise0_cyc = cyc;
        end
      end
    end
    checks++;
    if (rel != 11) begin errors++; $display("FAIL rise_latency: edge=%0d expected 11", rel); end
    checks++;
    if (n != 1) begin errors++; $display("FAIL rise_count: got=%0d expected 1", n); end
    checks++;
    if (evt !== 1'b1) begin errors++; $display("FAIL rise_event: got=%b expected 1", evt); end
    checks++;
    if (db_before !== 1'b0) begin errors++; $display("FAIL rise_early_level: got=%b expected 0", db_before); end
    checks++;
    if (db_level_o[0] !== 1'b1) begin errors++; $display("FAIL rise_level: got=%b expected 1", db_level_o[0]); end
  endtask

  task automatic test_long_press();
    int long_cyc = -1;
    int n = 0;
    int c0;
    int fall_rel = -1;
    int fn = 0;
    int rn = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (long_tick_o[0]) begin
        n++;
        if (long_cyc < 0) long_cyc = cyc;
      end
    end
    checks++;
    if (long_cyc - rise0_cyc != 30) begin
      errors++; $display("FAIL long_delay: got=%0d expected 30", long_cyc - rise0_cyc);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL long_count: got=%0d expected 1", n); end
    // release
    c0 = cyc;
    sw_i[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fall_tick_o[0]) begin
        fn++;
        if (fall_rel < 0) fall_rel = cyc - c0 - 1;
      end
    end
    checks++;
    if (fall_rel != 11) begin errors++; $display("FAIL fall_latency: edge=%0d expected 11", fall_rel); end
    checks++;
    if (fn != 1) begin errors++; $display("FAIL fall_count: got=%0d expected 1", fn); end
    // 20-clock press: level is high for only 20 clocks
    n = 0;
    fn = 0;
    sw_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rise_tick_o[0]) rn++;
      if (long_tick_o[0]) n++;
    end
    sw_i[0] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (long_tick_o[0]) n++;
      if (fall_tick_o[0]) fn++;
    end
    checks++;
    if (rn != 1 || fn != 1) begin
      errors++; $display("FAIL short_press_edges: rise=%0d fall=%0d expected 1 1", rn, fn);
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL short_press_long: got=%0d expected 0", n); end
  endtask

  task automatic test_glitch();
    int ticks = 0;
    logic lvl = 1'b0;
    sw_i[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (rise_tick_o[1] || fall_tick_o[1]) ticks++;
      lvl = lvl | db_level_o[1];
    end
    sw_i[1] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (rise_tick_o[1] || fall_tick_o[1]) ticks++;
      lvl = lvl | db_level_o[1];
    end
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL glitch_ticks: got=%0d expected 0", ticks); end
    checks++;
    if (lvl !== 1'b0) begin errors++; $display("FAIL glitch_level: got=%b expected 0", lvl); end
  endtask

  task automatic test_bounce();
    int c_last = 0;
    int rel = -1;
    int rn = 0;
    int fn = 0;
    for (int j = 0; j < 13; j++) begin
      sw_i[2] = (j % 2 == 0);
      c_last = cyc;
      for (int k = 0; k < 3; k++) begin
        step();
        if (rise_tick_o[2]) begin
          rn++;
          if (rel < 0) rel = cyc - c_last - 1;
        end
        if (fall_tick_o[2]) fn++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (rise_tick_o[2]) begin
        rn++;
        if (rel < 0) rel = cyc - c_last - 1;
      end
      if (fall_tick_o[2]) fn++;
    end
    checks++;
    if (rn != 1) begin errors++; $display("FAIL bounce_rise_count: got=%0d expected 1", rn); end
    checks++;
    if (rel != 11) begin errors++; $display("FAIL bounce_latency: edge=%0d expected 11", rel); end
    checks++;
    if (fn != 0) begin errors++; $display("FAIL bounce_fall_count: got=%0d expected 0", fn); end
  endtask

  task automatic test_simultaneous();
    int c0 = cyc;
    int n = 0;
    int rel = -1;
    logic [3:0] vec = 4'b0000;
    logic evt = 1'b0;
    sw_i[0] = 1'b1;
    sw_i[3] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (rise_tick_o != 4'b0000) begin
        n++;
        if (rel < 0) begin
          rel = cyc - c0 - 1;
          vec = rise_tick_o;
          evt = event_o;
        end
      end
    end
    checks++;
    if (vec !== 4'b1001) begin errors++; $display("FAIL simul_vector: got=%b expected 1001", vec); end
    checks++;
    if (n != 1 || rel != 11) begin
      errors++; $display("FAIL simul_timing: cycles=%0d edge=%0d expected 1 11", n, rel);
    end
    checks++;
    if (evt !== 1'b1) begin errors++; $display("FAIL simul_event: got=%b expected 1", evt); end
  endtask

  task automatic test_reset_mid();
    int c0;
    int rel = -1;
    logic [3:0] vec = 4'b0000;
    logic [3:0] db_before = 4'b1111;
    sw_i = 4'b1111;
    repeat (5) step();
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid_async: outputs=%h expected 0", {db_level_o, rise_tick_o, fall_tick_o, long_tick_o, event_o});
    end
    step();
    step();
    rst_i = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 10) db_before = db_level_o;
      if (rise_tick_o != 4'b0000 && rel < 0) begin
        rel = cyc - c0 - 1;
        vec = rise_tick_o;
      end
    end
    checks++;
    if (rel != 11 || vec !== 4'b1111) begin
      errors++; $display("FAIL reset_mid_rise: edge=%0d vec=%b expected 11 1111", rel, vec);
    end
    checks++;
    if (db_before !== 4'b0000) begin errors++; $display("FAIL reset_mid_early: got=%b expected 0000", db_before); end
    checks++;
    if (db_level_o !== 4'b1111) begin errors++; $display("FAIL reset_mid_level: got=%b expected 1111", db_level_o); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_long_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
